// File: rtl/song_mem_sequencer.sv
// Song memory sequencer: turns start/pause/mode/slot control and sample ticks into req/ack memory transactions.
// Optional PLAY_LOOP_EN: playback wraps to offset 0 at end of song instead of finishing.
module song_mem_sequencer #(
  parameter int unsigned OFF_W  = 15,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_song,
  input  logic                record_mode,
  input  logic [3:0]          song_choice,
  input  logic                pause_song,
  input  logic                sample_tick,
  input  logic [DATA_W-1:0]   rec_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [4+OFF_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   play_data,
  output logic                play_valid,
  output logic                song_done,
  output logic                overrun
);

  localparam int unsigned ADDR_W = 4 + OFF_W;
  localparam int unsigned LEN_W  = OFF_W + 1;
  localparam int unsigned SLOTS  = 16;

  typedef enum logic [1:0] {IDLE, RUN, XFER, FIN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          slot_q, slot_d;
  logic                rec_q, rec_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [LEN_W-1:0]    len_q [SLOTS];

  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d, play_data_d;
  logic                play_valid_d, song_done_d, overrun_d;

  logic                len_we;
  logic [3:0]          len_idx;
  logic [LEN_W-1:0]    len_wval;

  logic [LEN_W-1:0]    cur_len;
  logic                last_off;
  logic                play_end;

  assign cur_len  = len_q[slot_q];
  assign last_off = (offset_q == {OFF_W{1'b1}});
  assign play_end = ((LEN_W'(offset_q) + LEN_W'(1)) == cur_len);

  // State, datapath and length table registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      rec_q      <= 1'b0;
      offset_q   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      play_data  <= '0;
      play_valid <= 1'b0;
      song_done  <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      rec_q      <= rec_d;
      offset_q   <= offset_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      play_data  <= play_data_d;
      play_valid <= play_valid_d;
      song_done  <= song_done_d;
      overrun    <= overrun_d;
      if (len_we) len_q[len_idx] <= len_wval;
    end
  end

  // Next-state and output logic; start_song overrides everything, including a same-cycle ack
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    rec_d        = rec_q;
    offset_d     = offset_q;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    play_data_d  = play_data;
    play_valid_d = 1'b0;
    overrun_d    = overrun;
    len_we       = 1'b0;
    len_idx      = slot_q;
    len_wval     = '0;

    if (start_song) begin
      state_d   = RUN;
      slot_d    = song_choice;
      rec_d     = record_mode;
      offset_d  = '0;
      overrun_d = 1'b0;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      len_we    = record_mode;
      len_idx   = song_choice;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (!rec_q && (cur_len == '0)) begin
`ifdef PLAY_LOOP_EN
            state_d = RUN;
`else
            state_d = FIN;
`endif
          end else if (sample_tick && !pause_song) begin
            mem_req_d  = 1'b1;
            mem_we_d   = rec_q;
            mem_addr_d = {slot_q, offset_q};
            if (rec_q) mem_wdata_d = rec_data;
            state_d    = XFER;
          end
        end
        XFER: begin
          if (sample_tick) overrun_d = 1'b1;
          if (mem_ack) begin
            mem_req_d = 1'b0;
            offset_d  = offset_q + OFF_W'(1);
            if (rec_q) begin
              len_we   = 1'b1;
              len_wval = LEN_W'(offset_q) + LEN_W'(1);
              state_d  = last_off ? FIN : RUN;
            end else begin
              play_data_d  = mem_rdata;
              play_valid_d = 1'b1;
              if (play_end) begin
`ifdef PLAY_LOOP_EN
                offset_d = '0;
                state_d  = RUN;
`else
                state_d  = FIN;
`endif
              end else begin
                state_d = RUN;
              end
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    song_done_d = (state_d == FIN);
  end

endmodule

// File: tb/tb_song_mem_sequencer.sv
// Directed bench for song_mem_sequencer: table of record/playback songs plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_song_mem_sequencer;

  localparam int unsigned OFF_W  = 15;
  localparam int unsigned DATA_W = 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start_song, record_mode, pause_song, sample_tick;
  logic [3:0]          song_choice;
  logic [DATA_W-1:0]   rec_data, mem_rdata;
  logic                mem_req, mem_we, mem_ack;
  logic [4+OFF_W-1:0]  mem_addr;
  logic [DATA_W-1:0]   mem_wdata, play_data;
  logic                play_valid, song_done, overrun;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem_model [logic [4+OFF_W-1:0]];

  song_mem_sequencer #(.OFF_W(OFF_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start_song(start_song), .record_mode(record_mode),
    .song_choice(song_choice), .pause_song(pause_song), .sample_tick(sample_tick),
    .rec_data(rec_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .play_data(play_data), .play_valid(play_valid), .song_done(song_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rec;
    logic [3:0] slot;
    int         n;
    logic [7:0] base;
    int         dly;
    logic       done;
  } vec_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4+OFF_W-1:0] addr_of(input logic [3:0] s, input int off);
    return {s, OFF_W'(off)};
  endfunction

  task automatic start(input logic rec, input logic [3:0] s);
    record_mode = rec;
    song_choice = s;
    start_song  = 1'b1;
    cyc();
    start_song  = 1'b0;
  endtask

  // One song from the table: n ticks, each acked after dly cycles
  task automatic run_vec(input vec_t v);
    logic exp_done;
    start(v.rec, v.slot);
    chk("start_req", 32'(mem_req), 32'd0);
    chk("start_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < v.n; i++) begin
      sample_tick = 1'b1;
      rec_data    = v.base + 8'(i);
      cyc();
      sample_tick = 1'b0;
      rec_data    = '0;
      chk("req_rise", 32'(mem_req), 32'd1);
      chk("req_addr", 32'(mem_addr), 32'(addr_of(v.slot, i)));
      chk("req_we", 32'(mem_we), 32'(v.rec));
      if (v.rec) begin
        chk("req_wdata", 32'(mem_wdata), 32'(v.base + 8'(i)));
        mem_model[addr_of(v.slot, i)] = v.base + 8'(i);
      end
      for (int d = 0; d < v.dly; d++) begin
        cyc();
        chk("req_hold", 32'(mem_req), 32'd1);
      end
      mem_ack   = 1'b1;
      mem_rdata = mem_model.exists(addr_of(v.slot, i)) ? mem_model[addr_of(v.slot, i)] : 8'h00;
      cyc();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("req_fall", 32'(mem_req), 32'd0);
      chk("play_valid", 32'(play_valid), 32'(!v.rec));
      if (!v.rec) chk("play_data", 32'(play_data), 32'(v.base + 8'(i)));
`ifdef PLAY_LOOP_EN
      exp_done = 1'b0;
`else
      exp_done = v.done && (i == v.n - 1);
`endif
      chk("song_done", 32'(song_done), 32'(exp_done));
    end
`ifdef PLAY_LOOP_EN
    if (!v.rec) begin
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      chk("loop_addr", 32'(mem_addr), 32'(addr_of(v.slot, 0)));
      mem_ack = 1'b1;
      mem_rdata = mem_model[addr_of(v.slot, 0)];
      cyc();
      mem_ack = 1'b0;
      chk("loop_data", 32'(play_data), 32'(v.base));
    end
`else
    if (v.done) begin
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      chk("done_pulse_end", 32'(song_done), 32'd0);
      chk("idle_no_req", 32'(mem_req), 32'd0);
    end
`endif
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{rec: 1'b1, slot: 4'd3, n: 5, base: 8'h10, dly: 2, done: 1'b0};
    vecs[1] = '{rec: 1'b0, slot: 4'd3, n: 5, base: 8'h10, dly: 0, done: 1'b1};
    vecs[2] = '{rec: 1'b1, slot: 4'd5, n: 3, base: 8'hA0, dly: 1, done: 1'b0};
    vecs[3] = '{rec: 1'b0, slot: 4'd5, n: 3, base: 8'hA0, dly: 3, done: 1'b1};
    vecs[4] = '{rec: 1'b1, slot: 4'd3, n: 2, base: 8'h55, dly: 0, done: 1'b0};
    vecs[5] = '{rec: 1'b0, slot: 4'd3, n: 2, base: 8'h55, dly: 1, done: 1'b1};

    reset_n = 1'b0; start_song = 0; record_mode = 0; song_choice = 0; pause_song = 0;
    sample_tick = 0; rec_data = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) cyc();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_play_valid", 32'(play_valid), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    reset_n = 1'b1;
    cyc();

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Empty slot 7: done two cycles after start, never a request even with a tick
    start(1'b0, 4'd7);
    sample_tick = 1'b1;
    chk("empty_done_early", 32'(song_done), 32'd0);
    cyc();
    sample_tick = 1'b0;
`ifdef PLAY_LOOP_EN
    chk("empty_done", 32'(song_done), 32'd0);
`else
    chk("empty_done", 32'(song_done), 32'd1);
`endif
    chk("empty_no_req", 32'(mem_req), 32'd0);

    // Overrun: extra tick during XFER, offset advances by one only
    start(1'b1, 4'd9);
    sample_tick = 1'b1; rec_data = 8'h77;
    cyc();
    cyc();
    sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_addr0", 32'(mem_addr), 32'(addr_of(4'd9, 0)));
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("ovr_hold1", 32'(overrun), 32'd1);
    sample_tick = 1'b1; rec_data = 8'h78; cyc(); sample_tick = 1'b0;
    chk("ovr_addr1", 32'(mem_addr), 32'(addr_of(4'd9, 1)));
    chk("ovr_wdata1", 32'(mem_wdata), 32'h78);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("ovr_hold2", 32'(overrun), 32'd1);
    start(1'b0, 4'd9);
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Pause suppresses new transactions
    pause_song = 1'b1; sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("pause_no_req", 32'(mem_req), 32'd0);
    pause_song = 1'b0;

    // Restart while a request is outstanding; late ack and start+ack are ignored
    start(1'b0, 4'd3);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("abort_req", 32'(mem_req), 32'd1);
    start(1'b0, 4'd3);
    chk("abort_drop", 32'(mem_req), 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'hEE; cyc(); mem_ack = 1'b0;
    chk("late_ack_ignored", 32'(play_valid), 32'd0);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("restart_addr", 32'(mem_addr), 32'(addr_of(4'd3, 0)));
    mem_ack = 1'b1; mem_rdata = 8'h55; cyc(); mem_ack = 1'b0;
    chk("restart_data", 32'(play_data), 32'h55);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("second_addr", 32'(mem_addr), 32'(addr_of(4'd3, 1)));
    start_song = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h56;
    cyc();
    start_song = 1'b0; mem_ack = 1'b0;
    chk("start_ack_pv", 32'(play_valid), 32'd0);
    chk("start_ack_pd", 32'(play_data), 32'h55);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("start_ack_addr", 32'(mem_addr), 32'(addr_of(4'd3, 0)));

    // Asynchronous reset in the middle of a transfer
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_play_data", 32'(play_data), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    start(1'b0, 4'd3);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
`ifdef PLAY_LOOP_EN
    chk("len_cleared_done", 32'(song_done), 32'd0);
`else
    chk("len_cleared_done", 32'(song_done), 32'd1);
`endif
    chk("len_cleared_req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
